axi4l_reg_slave: RTL and testbench

AXI4-Lite responder (slave) exposing a bank of `NUM_REGS` read/write registers to an AXI4-Lite master. It terminates the slave side of the AXI4-Lite bus used across the design (testbench BFMs and on-chip masters) and presents register contents and per-register write strobes to fabric logic. One outstanding write and one outstanding read are supported; the read and write paths run independently.

---
 rtl/axi4l_reg_slave.sv | 123 ++++++++++++
 tb/tb_axi4l_reg_slave.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_reg_slave.sv
// axi4l_reg_slave: AXI4-Lite slave exposing NUM_REGS byte-writable registers,
// with independent single-outstanding read and write paths.
module axi4l_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
  output logic [NUM_REGS-1:0]            wr_stb
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = $clog2(NUM_REGS);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic aw_held, w_held, aw_ok, ar_ok;
  logic [IW-1:0] aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  // Shifting the whole address also rejects any set bit above the index field.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >> LSB) < ADDR_WIDTH'(NUM_REGS);
  endfunction
  assign ar_ok  = addr_ok(araddr);
  assign ar_idx = araddr[LSB +: IW];
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_ok   <= 1'b0;
      aw_idx  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      regs_q  <= '0;
      wr_stb  <= '0;
    end else begin
      wr_stb <= '0;
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= aw_ok ? 2'b00 : 2'b10;
            w_state <= W_RESP;
            if (aw_ok) begin
              wr_stb[aw_idx] <= 1'b1;
              for (int k = 0; k < SW; k++)
                if (wstrb_q[k]) regs_q[DATA_WIDTH*int'(aw_idx) + 8*k +: 8] <= wdata_q[8*k +: 8];
            end
          end
          if (awvalid && awready) begin
            aw_held <= 1'b1;
            awready <= 1'b0;
            aw_ok   <= addr_ok(awaddr);
            aw_idx  <= awaddr[LSB +: IW];
          end else if (!aw_held) awready <= 1'b1;
          if (wvalid && wready) begin
            w_held  <= 1'b1;
            wready  <= 1'b0;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
          end else if (!w_held) wready <= 1'b1;
        end
        W_RESP: if (bready) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          wready  <= 1'b1;
          w_state <= W_IDLE;
        end
      endcase
    end
  // Reads sample regs_q before any same-edge write commit lands.
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rresp   <= 2'b00;
      rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid && arready) begin
          arready <= 1'b0;
          rvalid  <= 1'b1;
          rresp   <= ar_ok ? 2'b00 : 2'b10;
          rdata   <= ar_ok ? regs_q[DATA_WIDTH*int'(ar_idx) +: DATA_WIDTH] : '0;
          r_state <= R_DATA;
        end else arready <= 1'b1;
        R_DATA: if (rready) begin
          rvalid  <= 1'b0;
          arready <= 1'b1;
          r_state <= R_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_axi4l_reg_slave.sv
// tb_axi4l_reg_slave: directed AXI4-Lite transactions with queued expected
// responses consumed by independent B and R channel monitors.
module tb_axi4l_reg_slave;
  logic clk = 1'b0, arstn = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0] wstrb = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
  logic awready, wready, arready, bvalid, rvalid;
  logic [1:0] bresp, rresp;
  logic [255:0] regs_q;
  logic [7:0] wr_stb;
  int n_chk = 0, n_fail = 0, cyc = 0, b_rise = 0;
  int stb_cnt[8] = '{default: 0};
  logic [31:0] model[8] = '{default: '0};
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  logic [33:0] r_exp;
  logic bv_prev = 1'b0;

  axi4l_reg_slave dut (
    .clk(clk), .arstn(arstn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_q(regs_q), .wr_stb(wr_stb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  function automatic int stb_total();
    int t = 0;
    foreach (stb_cnt[i]) t += stb_cnt[i];
    return t;
  endfunction

  function automatic logic [255:0] model_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = model[i];
    return v;
  endfunction

  // Monitors: pop expected responses as each B/R handshake is presented.
  always @(negedge clk) begin
    if (arstn) begin
      for (int i = 0; i < 8; i++) stb_cnt[i] += int'(wr_stb[i]);
      if (bvalid && !bv_prev) b_rise = cyc;
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL b_unexpected: bresp=%0h with no response expected", bresp);
        end else chk("bresp", bresp, bq.pop_front());
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL r_unexpected: rdata=%0h with no response expected", rdata);
        end else begin
          r_exp = rq.pop_front();
          chk("rresp", rresp, r_exp[33:32]);
          chk("rdata", rdata, r_exp[31:0]);
        end
      end
    end
    bv_prev = bvalid;
  end

  // Called and returns at posedge+1; idx<0 means an out-of-range address.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int idx,
                          input logic [31:0] ev, input string nm);
    int t0, s0, aw_hs, w_hs, kb;
    t0 = stb_total();
    s0 = idx >= 0 ? stb_cnt[idx] : 0;
    bq.push_back(idx >= 0 ? 2'b00 : 2'b10);
    if (idx >= 0) model[idx] = ev;
    fork
      begin
        int ka;
        ka = 0;
        repeat (aw_dly) begin @(posedge clk); #1; end
        awaddr = a;
        awvalid = 1'b1;
        do begin @(negedge clk); ka++; end while (!awready && ka < 50);
        if (!awready) tmo({nm, "_aw"});
        aw_hs = cyc + 1;
        @(posedge clk); #1 awvalid = 1'b0;
      end
      begin
        int kw;
        kw = 0;
        repeat (w_dly) begin @(posedge clk); #1; end
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        do begin @(negedge clk); kw++; end while (!wready && kw < 50);
        if (!wready) tmo({nm, "_w"});
        w_hs = cyc + 1;
        @(posedge clk); #1 wvalid = 1'b0;
      end
    join
    kb = 0;
    do begin @(negedge clk); kb++; end while (!(bvalid && bready) && kb < 50);
    if (!(bvalid && bready)) tmo({nm, "_b"});
    #1;
    chk({nm, "_blat"}, b_rise, (aw_hs > w_hs ? aw_hs : w_hs) + 1);
    @(posedge clk); #1;
    chk({nm, "_stb_total"}, stb_total() - t0, idx >= 0 ? 1 : 0);
    if (idx >= 0) chk({nm, "_stb_reg"}, stb_cnt[idx] - s0, 1);
    chk({nm, "_regs_q"}, regs_q, model_vec());
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er, input string nm);
    int k;
    rq.push_back({er, ed});
    araddr = a;
    arvalid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!arready && k < 50);
    if (!arready) tmo({nm, "_ar"});
    @(posedge clk); #1 arvalid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!(rvalid && rready) && k < 50);
    if (!(rvalid && rready)) tmo({nm, "_r"});
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(bq.size() == 0 && rq.size() == 0 && !bvalid && !rvalid) && k < 50);
    if (!(bq.size() == 0 && rq.size() == 0 && !bvalid && !rvalid)) tmo(nm);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ar_hs, t0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp}, 4'h0);
    chk("rst_rdata", rdata, 0);
    chk("rst_regs", regs_q, 0);
    chk("rst_stb", wr_stb, 0);
    arstn = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", {awready, wready, arready}, 3'b000);
    @(negedge clk);
    chk("rdy_after_edge", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) do_read(32'(i * 4), 32'h0, 2'b00, "rd_reset");
    chk("reset_regs_q", regs_q, 0);

    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 1, 32'hDEADBEEF, "wr_r1");
    do_read(32'h4, 32'hDEADBEEF, 2'b00, "rd_r1");
    do_read(32'h7, 32'hDEADBEEF, 2'b00, "rd_unaligned");

    do_write(32'h8, 32'h11223344, 4'hF, 0, 0, 2, 32'h11223344, "wr_r2");
    do_write(32'h8, 32'hAABBCCDD, 4'b0101, 0, 0, 2, 32'h11BB33DD, "wr_r2_strb");
    do_read(32'h8, 32'h11BB33DD, 2'b00, "rd_r2");

    do_write(32'h14, 32'h01020304, 4'hF, 3, 0, 5, 32'h01020304, "w_first");
    do_write(32'h18, 32'h05060708, 4'hF, 0, 3, 6, 32'h05060708, "aw_first");
    do_read(32'h14, 32'h01020304, 2'b00, "rd_r5");

    do_write(32'h20, 32'h12345678, 4'hF, 0, 0, -1, 32'h0, "wr_oor");
    do_read(32'h20, 32'h0, 2'b10, "rd_oor");
    do_read(32'h8000_0004, 32'h0, 2'b10, "rd_high_bit");
    do_write(32'h1C, 32'hFFFFFFFF, 4'h0, 0, 0, 7, 32'h0, "wr_strb0");

    // Backpressure: response channels stalled with everything outstanding.
    bready = 1'b0;
    rready = 1'b0;
    awaddr = 32'h10; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 32'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'hDEADBEEF});
    model[4] = 32'hCAFEF00D;
    @(negedge clk);
    chk("bp_rdy_pre", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valids", {bvalid, rvalid}, 2'b11);
      chk("bp_bresp", bresp, 2'b00);
      chk("bp_rresp", rresp, 2'b00);
      chk("bp_rdata", rdata, 32'hDEADBEEF);
      chk("bp_readies", {awready, wready, arready}, 3'b000);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    rready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_regs_q", regs_q, model_vec());

    // Collision: AR handshake on the same edge as a commit to reg3.
    do_write(32'hC, 32'h33333333, 4'hF, 0, 0, 3, 32'h33333333, "wr_r3");
    awaddr = 32'hC; wdata = 32'h44444444; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    bq.push_back(2'b00);
    model[3] = 32'h44444444;
    @(negedge clk);
    chk("coll_wrdy", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'hC; arvalid = 1'b1;
    rq.push_back({2'b00, 32'h33333333});
    @(negedge clk);
    chk("coll_arrdy", arready, 1'b1);
    ar_hs = cyc + 1;
    @(posedge clk); #1 arvalid = 1'b0;
    wait_drain("coll_drain");
    chk("coll_same_edge", b_rise, ar_hs);
    do_read(32'hC, 32'h44444444, 2'b00, "rd_r3_new");
    chk("coll_regs_q", regs_q, model_vec());

    // Reset during a write between handshake and commit.
    awaddr = 32'h0; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    arstn = 1'b0;
    #1;
    chk("mid_regs_async", regs_q, 0);
    chk("mid_ready", {awready, wready, arready}, 3'b000);
    t0 = stb_total();
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("mid_bvalid", bvalid, 1'b0);
    end
    chk("mid_stb", stb_total() - t0, 0);
    chk("mid_regs", regs_q, 0);
    chk("mid_rdy", {awready, wready, arready}, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
